// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - 10 ms tick to game-step request scheduler with req/ack handshake
module game_tick_scheduler #(
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = 20,
    parameter int OVR_W          = 8
) (
    input  logic        mclk,
    input  logic        clr,
    input  logic        tick_10ms,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        step_req,
    input  logic        step_ack,
    output logic        running,
    output logic        overrun
);

    typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

    localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_div_cnt;
    logic [15:0]         r_step_cnt;
    logic [OVR_W-1:0]    r_ovr_cnt;
    logic                r_req;
    logic                r_running;
    logic                r_overrun;
    logic [15:0]         r_rdata;

    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_status;
    logic                w_terminal;
    logic                w_fire;
    logic [PERIOD_W-1:0] w_period_val;
    logic [OVR_W-1:0]    w_ovr_nxt;
    state_t              w_state_nxt;
    logic [15:0]         w_rd_mux;

    assign w_wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
    assign w_wr_period = cfg_we && (cfg_addr == 2'd1);
    assign w_wr_status = cfg_we && (cfg_addr == 2'd2);
    assign w_terminal  = (r_div_cnt == r_period - ONE);

    // A PERIOD write in the terminal-tick cycle suppresses that tick's fire.
    assign w_fire = ((r_state == ST_RUNNING) && tick_10ms && w_terminal && !w_wr_period)
                  || (w_wr_ctrl && cfg_wdata[1]);

    assign w_period_val = (cfg_wdata[PERIOD_W-1:0] == '0) ? ONE : cfg_wdata[PERIOD_W-1:0];
    assign w_state_nxt  = w_wr_ctrl ? (cfg_wdata[0] ? ST_RUNNING : ST_STOPPED) : r_state;

    always_comb begin
        w_ovr_nxt = r_ovr_cnt;
        if (w_wr_status)
            w_ovr_nxt = '0;
        else if (w_fire && r_req && !step_ack && !(&r_ovr_cnt))
            w_ovr_nxt = r_ovr_cnt + 1'b1;
    end

    always_comb begin
        w_rd_mux = 16'd0;
        case (cfg_addr)
            2'd0:    w_rd_mux = {15'd0, r_running};
            2'd1:    w_rd_mux = 16'(r_period);
            2'd2:    w_rd_mux = 16'({r_req, r_ovr_cnt});
            default: w_rd_mux = r_step_cnt;
        endcase
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_STOPPED;
            r_period   <= PERIOD_W'(DEFAULT_PERIOD);
            r_div_cnt  <= '0;
            r_step_cnt <= 16'd0;
            r_ovr_cnt  <= '0;
            r_req      <= 1'b0;
            r_running  <= 1'b0;
            r_overrun  <= 1'b0;
            r_rdata    <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUNNING);
            r_ovr_cnt <= w_ovr_nxt;
            r_overrun <= |w_ovr_nxt;
            r_rdata   <= w_rd_mux;

            if (w_wr_period) begin
                r_period  <= w_period_val;
                r_div_cnt <= '0;
            end else if (w_wr_ctrl && cfg_wdata[0] && (r_state == ST_STOPPED)) begin
                r_div_cnt <= '0;
            end else if ((r_state == ST_RUNNING) && tick_10ms) begin
                r_div_cnt <= w_terminal ? '0 : r_div_cnt + ONE;
            end

            if (r_req && step_ack)
                r_step_cnt <= r_step_cnt + 16'd1;

            if (w_fire)
                r_req <= 1'b1;
            else if (r_req && step_ack)
                r_req <= 1'b0;
        end
    end

    assign cfg_rdata = r_rdata;
    assign step_req  = r_req;
    assign running   = r_running;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - randomized bench for game_tick_scheduler against a behavioural model
module tb_game_tick_scheduler;

    logic        mclk = 1'b0;
    logic        clr = 1'b0;
    logic        tick_10ms = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'd0;
    logic        step_ack = 1'b0;
    logic [15:0] cfg_rdata;
    logic        step_req;
    logic        running;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int req_rises = 0;
    bit prev_req = 1'b0;

    bit m_run, m_req;
    int m_period, m_div, m_steps, m_ovr, m_rd;

    game_tick_scheduler dut (
        .mclk      (mclk),
        .clr       (clr),
        .tick_10ms (tick_10ms),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .running   (running),
        .overrun   (overrun)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_req = 0; m_period = 20; m_div = 0; m_steps = 0; m_ovr = 0; m_rd = 0;
    endtask

    // One clock of the scheduler's rules, applied to the state seen before the edge.
    task automatic model_step(input bit tk, input bit we, input bit [1:0] a,
                              input bit [15:0] d, input bit ack);
        bit fire;
        int nd;
        case (a)
            2'd0:    m_rd = m_run;
            2'd1:    m_rd = m_period;
            2'd2:    m_rd = (m_req ? 256 : 0) + m_ovr;
            default: m_rd = m_steps;
        endcase
        fire = 0;
        nd   = m_div;
        if (m_run && tk) begin
            nd   = (m_div + 1) % m_period;
            fire = (nd == 0);
        end
        if (we && a == 2'd1) begin
            m_period = (d == 0) ? 1 : int'(d);
            nd   = 0;
            fire = 0;
        end
        if (we && a == 2'd0) begin
            if (d[0] && !m_run) nd = 0;
            m_run = d[0];
            if (d[1]) fire = 1;
        end
        m_div = nd;
        if (m_req && ack) m_steps = (m_steps + 1) % 65536;
        if (fire && m_req && !ack && m_ovr < 255) m_ovr++;
        if (we && a == 2'd2) m_ovr = 0;
        m_req = fire || (m_req && !ack);
    endtask

    task automatic cyc(input bit tk, input bit we, input bit [1:0] a,
                       input bit [15:0] d, input bit ack);
        tick_10ms = tk; cfg_we = we; cfg_addr = a; cfg_wdata = d; step_ack = ack;
        @(posedge mclk);
        model_step(tk, we, a, d, ack);
        #1;
        check("step_req", {31'd0, step_req}, {31'd0, m_req});
        check("running", {31'd0, running}, {31'd0, m_run});
        check("overrun", {31'd0, overrun}, {31'd0, (m_ovr != 0)});
        check("cfg_rdata", {16'd0, cfg_rdata}, m_rd);
        if (step_req === 1'b1 && !prev_req) req_rises++;
        prev_req = (step_req === 1'b1);
        tick_10ms = 0; cfg_we = 0; step_ack = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 16'd0, 0);
    endtask

    task automatic wr(input bit [1:0] a, input bit [15:0] d);
        cyc(0, 1, a, d, 0);
    endtask

    task automatic rd(input bit [1:0] a);
        cyc(0, 0, a, 16'd0, 0);
    endtask

    initial begin
        #1 clr = 1'b1;
        model_reset();
        #1;
        check("rst_req", {31'd0, step_req}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rdata", {16'd0, cfg_rdata}, 32'd0);
        @(posedge mclk);
        #1 clr = 1'b0;

        // T1: reset values, ack ignored while no request
        rd(2'd1);
        check("t1_period", {16'd0, cfg_rdata}, 32'd20);
        cyc(0, 0, 2'd3, 16'd0, 1);
        rd(2'd3);
        check("t1_steps", {16'd0, cfg_rdata}, 32'd0);

        // T2: period 3, nine ticks, each step acked two cycles after it appears
        wr(2'd1, 16'd3);
        wr(2'd0, 16'd1);
        req_rises = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 2'd0, 16'd0, 0);
            idle(1);
            cyc(0, 0, 2'd0, 16'd0, m_req);
            idle(1);
        end
        check("t2_rises", req_rises, 32'd3);
        rd(2'd3);
        check("t2_steps", {16'd0, cfg_rdata}, 32'd3);
        rd(2'd2);
        check("t2_status", {16'd0, cfg_rdata}, 32'd0);

        // T3: period 1, unacked ticks overrun and saturate
        wr(2'd1, 16'd1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, 16'd0, 0);
        rd(2'd2);
        check("t3_ovr4", {16'd0, cfg_rdata}, 32'h104);
        for (int i = 0; i < 300; i++) cyc(1, 0, 2'd0, 16'd0, 0);
        rd(2'd2);
        check("t3_ovr_sat", {16'd0, cfg_rdata}, 32'h1FF);
        check("t3_overrun", {31'd0, overrun}, 32'd1);

        // T4: fire and ack together while pending
        wr(2'd2, 16'd0);
        cyc(1, 0, 2'd0, 16'd0, 1);
        check("t4_req", {31'd0, step_req}, 32'd1);
        rd(2'd3);
        check("t4_steps", {16'd0, cfg_rdata}, 32'd4);
        rd(2'd2);
        check("t4_status", {16'd0, cfg_rdata}, 32'h100);

        // T5: stopped, single step, ticks ignored, period 0 stored as 1
        wr(2'd0, 16'd0);
        cyc(0, 0, 2'd0, 16'd0, 1);
        check("t5_req_clr", {31'd0, step_req}, 32'd0);
        wr(2'd0, 16'd2);
        check("t5_single", {31'd0, step_req}, 32'd1);
        check("t5_stopped", {31'd0, running}, 32'd0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 2'd0, 16'd0, 0);
        check("t5_no_ovr", {31'd0, overrun}, 32'd0);
        wr(2'd1, 16'd0);
        rd(2'd1);
        check("t5_period1", {16'd0, cfg_rdata}, 32'd1);

        // T6: clr while a step is pending mid-count
        cyc(0, 0, 2'd0, 16'd0, 1);
        wr(2'd1, 16'd5);
        wr(2'd0, 16'd1);
        cyc(1, 0, 2'd0, 16'd0, 0);
        cyc(1, 0, 2'd0, 16'd0, 0);
        wr(2'd0, 16'd3);
        check("t6_req_pre", {31'd0, step_req}, 32'd1);
        clr = 1'b1;
        model_reset();
        #1;
        check("t6_req", {31'd0, step_req}, 32'd0);
        check("t6_running", {31'd0, running}, 32'd0);
        check("t6_rdata", {16'd0, cfg_rdata}, 32'd0);
        @(posedge mclk);
        #1 clr = 1'b0;
        prev_req = 1'b0;
        rd(2'd3);
        check("t6_steps", {16'd0, cfg_rdata}, 32'd0);
        rd(2'd1);
        check("t6_period", {16'd0, cfg_rdata}, 32'd20);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bit tk, we, ack;
            bit [1:0] a;
            bit [15:0] d;
            tk  = ($urandom_range(0, 2) == 0);
            we  = ($urandom_range(0, 5) == 0);
            a   = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 2) == 0);
            if (a == 2'd1)
                d = 16'($urandom_range(0, 4));
            else if (a == 2'd0)
                d = {14'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
            else
                d = 16'($urandom);
            cyc(tk, we, a, d, ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
